// File: rtl/rf_readback_ctrl_pkg.sv
// Shared definitions for the RF read-back controller: FSM encoding,
// default widths and a small sizing helper.
package rf_readback_ctrl_pkg;

  localparam int DEFAULT_N         = 32;
  localparam int DEFAULT_ADDR_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rb_state_t;

  // Width of an occupancy counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rf_readback_ctrl_fifo.sv
// Small first-word-fall-through FIFO used as the output buffer of the
// read-back controller. Head entry is visible on head_data while !empty.
module rf_rb_fifo
  import rf_readback_ctrl_pkg::*;
#(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_reg [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  // Pointer difference gives occupancy; the extra MSB separates full from empty.
  always_comb begin
    count     = wr_ptr_reg - rd_ptr_reg;
    full      = (count == (AW + 1)'(DEPTH));
    empty     = (count == '0);
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    head_data = mem_reg[rd_ptr_reg[AW-1:0]];
  end

  // Storage array, written at the write pointer; no reset needed for contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointer advance.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rf_readback_ctrl.sv
// Sweeps a contiguous RF address window through the RF read port and streams
// the returned words out on a valid/ready interface with start/done sequencing.
module rf_readback_ctrl
  import rf_readback_ctrl_pkg::*;
#(
  parameter int N              = DEFAULT_N,
  parameter int RF_Addr_BITNES = DEFAULT_ADDR_BITS,
  parameter int RD_LATENCY     = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [RF_Addr_BITNES-1:0] i_base_addr,
  input  logic [RF_Addr_BITNES-1:0] i_count,
  output logic [RF_Addr_BITNES-1:0] o_rf_addr,
  output logic                      o_rf_re,
  input  logic [N-1:0]              i_rf_data,
  output logic [N-1:0]              o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  rb_state_t                 state_reg;
  rb_state_t                 state_next;
  logic [RF_Addr_BITNES-1:0] addr_reg;
  logic [RF_Addr_BITNES-1:0] remaining_reg;
  logic [RD_LATENCY-1:0]     pipe_valid_reg;
  logic [RD_LATENCY-1:0]     pipe_last_reg;
  logic [CW-1:0]             fifo_count;
  logic [CW-1:0]             inflight;
  logic [CW:0]               occupancy;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [N:0]                fifo_head;
  logic                      issue;
  logic                      issue_last;
  logic                      last_handshake;

  // Issue only while buffered plus in-flight words leave room, so a returning
  // word always has a FIFO slot and never needs to be blocked.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_valid_reg[i]);
    end
    occupancy      = {1'b0, fifo_count} + {1'b0, inflight};
    issue          = (state_reg == ST_RUN) && !fifo_full &&
                     (occupancy < (CW + 1)'(FIFO_DEPTH));
    issue_last     = (remaining_reg == {{(RF_Addr_BITNES-1){1'b0}}, 1'b1});
    fifo_push      = pipe_valid_reg[RD_LATENCY-1];
    fifo_pop       = o_valid && i_ready;
    last_handshake = fifo_pop && o_last;
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (i_start) state_next = (i_count == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && issue_last) state_next = ST_DRAIN;
      ST_DRAIN: if (last_handshake) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Address and remaining-word counters: loaded on an accepted start, stepped per issue.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
    end else if ((state_reg == ST_IDLE) && i_start) begin
      addr_reg      <= i_base_addr;
      remaining_reg <= i_count;
    end else if (issue) begin
      addr_reg      <= addr_reg + 1'b1;
      remaining_reg <= remaining_reg - 1'b1;
    end
  end

  // Read-latency pipe: tracks which cycles carry returning data and the last flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pipe_valid_reg <= '0;
      pipe_last_reg  <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_last_reg[i]  <= pipe_last_reg[i-1];
      end
      pipe_valid_reg[0] <= issue;
      pipe_last_reg[0]  <= issue && issue_last;
    end
  end

  rf_rb_fifo #(
    .W     (N + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .srst      (i_reset),
    .push      (fifo_push),
    .push_data ({pipe_last_reg[RD_LATENCY-1], i_rf_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Output decode: stream side comes from the FIFO head, status from the state.
  always_comb begin
    o_rf_re   = issue;
    o_rf_addr = addr_reg;
    o_valid   = !fifo_empty;
    o_data    = fifo_head[N-1:0];
    o_last    = !fifo_empty && fifo_head[N];
    o_busy    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    o_done    = (state_reg == ST_DONE);
  end

endmodule

// File: tb/tb_rf_readback_ctrl.sv
// Directed bench for rf_readback_ctrl: an RF model answers reads, a scoreboard
// holds expected addresses and words, and a monitor checks every cycle.
module tb_rf_readback_ctrl;

  localparam int DEPTH  = 4;
  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_DONE = 2;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [31:0] i_count;
  logic [31:0] o_rf_addr;
  logic        o_rf_re;
  logic [31:0] i_rf_data;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_busy;
  logic        o_done;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;
  int hs_total  = 0;
  int outstanding = 0;
  int m_state   = M_IDLE;
  int start_cyc;

  logic [32:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          hs_cyc_q[$];

  rf_readback_ctrl dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_count     (i_count),
    .o_rf_addr   (o_rf_addr),
    .o_rf_re     (o_rf_re),
    .i_rf_data   (i_rf_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] rf_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'd16;
      32'd1:   return 32'd4;
      32'd2:   return 32'd4;
      32'd3:   return 32'd4;
      default: return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endcase
  endfunction

  // RF read port model with one cycle of latency.
  always @(posedge clk) begin
    if (o_rf_re) i_rf_data <= rf_word(o_rf_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares issues and handshakes against the scoreboard and
  // tracks the expected busy/done sequence.
  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] a;
    logic        hs;
    logic        exp_last;
    exp_last = 1'b0;
    if (i_reset) begin
      exp_q.delete();
      exp_addr_q.delete();
      outstanding = 0;
      m_state     = M_IDLE;
    end else begin
      check("busy", o_busy, m_state == M_ACT);
      check("done", o_done, m_state == M_DONE);
      if (m_state != M_ACT) begin
        check("idle_valid", o_valid, 0);
        check("idle_re", o_rf_re, 0);
      end
      hs = o_valid && i_ready;
      if (o_rf_re) begin
        check("issue_room", outstanding < DEPTH, 1);
        if (exp_addr_q.size() == 0) begin
          check("re_unexpected", o_rf_re, 0);
        end else begin
          a = exp_addr_q.pop_front();
          check("rf_addr", o_rf_addr, a);
        end
        outstanding++;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("valid_unexpected", o_valid, 0);
        end else begin
          e = exp_q.pop_front();
          exp_last = e[32];
          check("data", o_data, e[31:0]);
          check("last", o_last, e[32]);
        end
        hs_cyc_q.push_back(cyc);
        hs_total++;
        outstanding--;
      end
      case (m_state)
        M_IDLE:  if (i_start) m_state = (i_count == 0) ? M_DONE : M_ACT;
        M_ACT:   if (hs && exp_last) m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  task automatic start_sweep(input logic [31:0] base, input logic [31:0] cnt);
    logic [31:0] ad;
    for (int k = 0; k < int'(cnt); k++) begin
      ad = base + 32'(k);
      exp_q.push_back({(k == int'(cnt) - 1), rf_word(ad)});
      exp_addr_q.push_back(ad);
    end
    start_cyc   = cyc;
    i_start     = 1'b1;
    i_base_addr = base;
    i_count     = cnt;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(m_state == M_IDLE && exp_q.size() == 0) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, n < 500, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int h0;
    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_count     = '0;
    i_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    check("rst_re",    o_rf_re, 0);
    check("rst_addr",  o_rf_addr, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last",  o_last, 0);
    check("rst_busy",  o_busy, 0);
    check("rst_done",  o_done, 0);
    @(posedge clk); #1;

    // Preloaded words, full throughput, first-word latency of three cycles.
    hs_cyc_q.delete();
    start_sweep(32'd0, 32'd4);
    wait_idle("t1_timeout");
    check("t1_count", hs_cyc_q.size(), 4);
    if (hs_cyc_q.size() == 4) begin
      check("t1_latency", hs_cyc_q[0], start_cyc + 3);
      for (int i = 1; i < 4; i++) check("t1_back2back", hs_cyc_q[i], hs_cyc_q[0] + i);
    end

    // Zero-length sweep: straight to done, nothing issued.
    start_sweep(32'd5, 32'd0);
    check("t2_done", o_done, 1);
    check("t2_valid", o_valid, 0);
    check("t2_re", o_rf_re, 0);
    wait_idle("t2_timeout");

    // Address wrap across the top of the address space.
    start_sweep(32'hFFFF_FFFE, 32'd4);
    wait_idle("t3_timeout");

    // Back-pressure: toggling ready, then a long stall.
    start_sweep(32'd100, 32'd16);
    for (int i = 0; i < 12; i++) begin
      i_ready = (i % 2) == 1;
      @(posedge clk); #1;
    end
    i_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t4_stall_re", o_rf_re, 0);
    check("t4_stall_valid", o_valid, 1);
    i_ready = 1'b1;
    wait_idle("t4_timeout");

    // Reset in the middle of a sweep, then a fresh sweep.
    h0 = hs_total;
    start_sweep(32'd200, 32'd8);
    n = 0;
    while (hs_total < h0 + 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_wait", n < 200, 1);
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    check("t5_re",    o_rf_re, 0);
    check("t5_addr",  o_rf_addr, 0);
    check("t5_valid", o_valid, 0);
    check("t5_last",  o_last, 0);
    check("t5_busy",  o_busy, 0);
    check("t5_done",  o_done, 0);
    repeat (3) @(posedge clk);
    #1;
    start_sweep(32'd0, 32'd2);
    wait_idle("t5_timeout");

    // Start pulse during a sweep must be ignored.
    start_sweep(32'd300, 32'd6);
    repeat (2) @(posedge clk);
    #1;
    i_start     = 1'b1;
    i_base_addr = 32'd999;
    i_count     = 32'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_idle("t6_timeout");
    check("t6_addr_q", exp_addr_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
